// File: rtl/uart_rx_pkg.sv
// UART RX bit timer shared types and helpers.
// State encoding, prescale legality and frame-length arithmetic.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE,
        ERR
    } rx_state_e;

    localparam int unsigned PRESCALE_MIN = 8;

    // Power of two inside PRESCALE_MIN..max.
    function automatic logic prescale_legal(
        input int unsigned value,
        input int unsigned max
    );
        return (value >= PRESCALE_MIN) && (value <= max) &&
               ((value & (value - 1)) == 0);
    endfunction

    // Start + data + optional parity + stop.
    function automatic int unsigned frame_len(
        input int unsigned dw,
        input logic        par
    );
        return 2 + dw + 32'(par);
    endfunction

endpackage

// File: rtl/uart_rx_edge_ctr.sv
// Oversampling edge counter: wraps to 0 after term.
// Clear has priority over enable; tc flags the terminal value.
module uart_rx_edge_ctr #(
    parameter int EW = 5
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          clr,
    input  logic          en,
    input  logic [EW-1:0] term,
    output logic [EW-1:0] cnt,
    output logic          tc
);

    logic [EW-1:0] cnt_q;
    logic [EW-1:0] cnt_d;

    assign tc  = (cnt_q == term);
    assign cnt = cnt_q;

    // Next count: clear, wrap at terminal, or step.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tc ? '0 : cnt_q + EW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_bit_timer.sv
// UART RX edge/bit timer with saturating end of frame.
// Define UART_RX_MAJORITY_EN for a 3-edge sample window and sample_last.
module uart_rx_bit_timer
    import uart_rx_pkg::*;
#(
    parameter  int PRESCALE_MAX = 32,
    parameter  int DATA_WIDTH   = 8,
    localparam int EW           = $clog2(PRESCALE_MAX),
    localparam int BW           = $clog2(DATA_WIDTH + 3)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          cnt_en,
    input  logic [EW:0]   prescale,
    input  logic          par_en,
    output logic [EW-1:0] edge_cnt,
    output logic [BW-1:0] bit_cnt,
    output logic          sample_strb,
    output logic          bit_done,
    output logic          frame_done,
    output logic          cfg_err
`ifdef UART_RX_MAJORITY_EN
   ,output logic          sample_last
`endif
);

    rx_state_e     state_q, state_d;
    logic [EW:0]   prescale_q, prescale_d;
    logic          par_q, par_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic          cfg_err_q, cfg_err_d;

    logic          legal;
    logic          run;
    logic          last_bit;
    logic          ctr_en;
    logic          tc;
    logic [EW-1:0] term;
    logic [EW-1:0] half;

    assign legal    = prescale_legal(32'(prescale_q), 32'(PRESCALE_MAX));
    assign run      = (state_q == RUN);
    assign term     = EW'(prescale_q - (EW+1)'(1));
    assign half     = prescale_q[EW:1];
    assign last_bit = (bit_cnt_q == BW'(frame_len(DATA_WIDTH, par_q) - 1));

    // The first enabled edge in IDLE already counts as edge 1.
    assign ctr_en = cnt_en && (run || (state_q == IDLE && legal));

    uart_rx_edge_ctr #(
        .EW (EW)
    ) u_edge_ctr (
        .CLK  (CLK),
        .RST  (RST),
        .clr  (!ctr_en),
        .en   (ctr_en),
        .term (term),
        .cnt  (edge_cnt),
        .tc   (tc)
    );

    assign bit_done   = run && tc;
    assign frame_done = bit_done && last_bit;
    assign bit_cnt    = bit_cnt_q;
    assign cfg_err    = cfg_err_q;

`ifdef UART_RX_MAJORITY_EN
    assign sample_strb = run && (edge_cnt == half - EW'(1) ||
                                 edge_cnt == half ||
                                 edge_cnt == half + EW'(1));
    assign sample_last = run && (edge_cnt == half + EW'(1));
`else
    assign sample_strb = run && (edge_cnt == half);
`endif

    // Next state, bit counter, error flag and config capture.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        cfg_err_d  = cfg_err_q;
        prescale_d = prescale_q;
        par_d      = par_q;
        if (state_q == IDLE) begin
            prescale_d = prescale;
            par_d      = par_en;
        end
        if (!cnt_en) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            cfg_err_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d   = legal ? RUN : ERR;
                    cfg_err_d = !legal;
                    bit_cnt_d = '0;
                end
                RUN: begin
                    if (frame_done) begin
                        state_d   = DONE;
                        bit_cnt_d = '0;
                    end else if (bit_done) begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
                DONE: begin
                    bit_cnt_d = '0;
                end
                ERR: begin
                    cfg_err_d = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and configuration registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            prescale_q <= (EW+1)'(PRESCALE_MIN);
            par_q      <= 1'b0;
            bit_cnt_q  <= '0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            prescale_q <= prescale_d;
            par_q      <= par_d;
            bit_cnt_q  <= bit_cnt_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

endmodule
